// File: rtl/bus_arb_pkg.sv
// Shared definitions for the system-bus arbiter: FSM state encoding and a
// constant-friendly ceiling-log2 helper used to size index and counter fields.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_HANDOVER = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requester found scanning
// upward from the index after last_i, wrapping modulo N.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);

  assign any_o = |req_i;

  // Scan from farthest to nearest offset so the nearest requester overwrites.
  always_comb begin
    winner_o = last_i;
    for (int off = N; off >= 1; off--) begin
      winner_o = req_i[IW'((int'(last_i) + off) % N)] ? IW'((int'(last_i) + off) % N)
                                                      : winner_o;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared system bus with an idle-timeout watchdog.
// Reset deassertion is assumed to be synchronised to clk by the reset source.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int BUS_ADR_WIDTH  = 16,
  parameter int BUS_DATA_WIDTH = 16,
  parameter int IDLE_TIMEOUT   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS-1:0]                m_req,
  output logic [NUM_MASTERS-1:0]                m_gnt,
  input  logic [NUM_MASTERS*BUS_ADR_WIDTH-1:0]  m_address,
  input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] m_dataout,
  input  logic [NUM_MASTERS-1:0]                m_rd,
  input  logic [NUM_MASTERS-1:0]                m_wr,
  output logic [BUS_DATA_WIDTH-1:0]             m_datain,
  output logic [NUM_MASTERS-1:0]                m_ready,
  output logic [BUS_ADR_WIDTH-1:0]              bus_address,
  output logic [BUS_DATA_WIDTH-1:0]             bus_dataout,
  output logic                                  bus_rd,
  output logic                                  bus_wr,
  input  logic [BUS_DATA_WIDTH-1:0]             bus_datain,
  input  logic                                  bus_ready
);

  localparam int IW = (clog2(NUM_MASTERS) > 0) ? clog2(NUM_MASTERS) : 1;
  localparam int CW = (clog2(IDLE_TIMEOUT + 1) > 0) ? clog2(IDLE_TIMEOUT + 1) : 1;
  localparam bit WD_ON = (IDLE_TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(IDLE_TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;

  logic [IW-1:0] pick_winner;
  logic          pick_any;
  logic          owner_strobe;
  logic          owner_req;
  logic          wd_expire;

  rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req_i    (m_req),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  assign owner_strobe = m_rd[owner_q] | m_wr[owner_q];
  assign owner_req    = m_req[owner_q];
  assign wd_expire    = WD_ON && !owner_strobe && (cnt_q == CNT_LAST);

  // State, ownership, watchdog and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state: arbitration in IDLE/HANDOVER, release or revocation in GRANT.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_HANDOVER: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          owner_d = pick_winner;
          last_d  = pick_winner;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req || wd_expire) begin
          state_d = ST_HANDOVER;
          cnt_d   = '0;
        end else if (owner_strobe) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant decode plus bus/ready steering from the registered owner.
  always_comb begin
    gnt_d       = (state_d == ST_GRANT) ? (NUM_MASTERS'(1) << owner_d) : '0;
    bus_address = '0;
    bus_dataout = '0;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    m_ready     = '0;
    if (state_q == ST_GRANT) begin
      bus_address      = m_address[int'(owner_q)*BUS_ADR_WIDTH +: BUS_ADR_WIDTH];
      bus_dataout      = m_dataout[int'(owner_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
      bus_rd           = m_rd[owner_q];
      bus_wr           = m_wr[owner_q];
      m_ready[owner_q] = bus_ready;
    end else begin
      m_ready = '0;
    end
  end

  assign m_gnt    = gnt_q;
  assign m_datain = bus_datain;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a tenure-level reference model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_gnt;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_dataout;
  logic [N-1:0]    m_rd;
  logic [N-1:0]    m_wr;
  logic [DW-1:0]   m_datain;
  logic [N-1:0]    m_ready;
  logic [AW-1:0]   bus_address;
  logic [DW-1:0]   bus_dataout;
  logic            bus_rd;
  logic            bus_wr;
  logic [DW-1:0]   bus_datain;
  logic            bus_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 when nobody holds the bus), the most
  // recent owner, and the length of the owner's current run of idle cycles.
  int own;
  int last;
  int idle;

  bus_arbiter #(
    .NUM_MASTERS(N), .BUS_ADR_WIDTH(AW), .BUS_DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_gnt(m_gnt),
    .m_address(m_address), .m_dataout(m_dataout), .m_rd(m_rd), .m_wr(m_wr),
    .m_datain(m_datain), .m_ready(m_ready),
    .bus_address(bus_address), .bus_dataout(bus_dataout),
    .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_datain(bus_datain), .bus_ready(bus_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: simulation still running at time %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    own  = -1;
    last = N - 1;
    idle = 0;
  endtask

  // One clock edge of the arbitration rules, applied to the inputs in effect.
  task automatic model_edge();
    int run;
    bit strobe;
    if (!rst) begin
      model_reset();
    end else if (own >= 0) begin
      strobe = m_rd[own] | m_wr[own];
      run    = strobe ? 0 : idle + 1;
      if (!m_req[own] || (TO > 0 && run >= TO)) begin
        own = -1;
      end else begin
        idle = run;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (m_req[(last + k) % N]) begin
          own  = (last + k) % N;
          last = own;
          idle = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]  eg;
    logic [N-1:0]  erdy;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          er;
    logic          ew;
    eg = '0; erdy = '0; ea = '0; ed = '0; er = 1'b0; ew = 1'b0;
    if (own >= 0) begin
      eg   = 4'b0001 << own;
      erdy = bus_ready ? (4'b0001 << own) : 4'b0000;
      ea   = m_address[own*AW +: AW];
      ed   = m_dataout[own*DW +: DW];
      er   = m_rd[own];
      ew   = m_wr[own];
    end
    check_val("m_gnt", m_gnt, eg);
    check_val("m_ready", m_ready, erdy);
    check_val("bus_address", bus_address, ea);
    check_val("bus_dataout", bus_dataout, ed);
    check_val("bus_rd", bus_rd, er);
    check_val("bus_wr", bus_wr, ew);
    check_val("m_datain", m_datain, bus_datain);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic int gnt_index(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) begin
      if (g[k]) r = k;
    end
    return r;
  endfunction

  initial begin
    int seen[$];
    int exp_rr[5];
    int gap;
    int held;
    int o;
    int cnt;
    bit in_ten;
    bit quiet;

    exp_rr = '{0, 1, 2, 3, 0};
    rst = 1'b0;
    m_req = 4'b1111;
    m_address = '0; m_dataout = '0; m_rd = '0; m_wr = '0;
    bus_datain = '0; bus_ready = 1'b0;
    model_reset();

    // Reset with every master requesting: no grant while reset is held.
    #1;
    check_val("rst_gnt", m_gnt, 4'b0000);
    check_val("rst_bus_rd", bus_rd, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    check_val("first_gnt", m_gnt, 4'b0001);

    // Round robin with every owner dropping req after three cycles.
    gap = 0; held = 0; in_ten = 1'b0;
    for (int i = 0; i < 60 && seen.size() < 5; i++) begin
      if (m_gnt != 4'b0000) begin
        o = gnt_index(m_gnt);
        if (!in_ten) begin
          if (seen.size() > 0) check_val("rr_gap", gap, 1);
          seen.push_back(o);
          in_ten = 1'b1;
          held = 0;
          gap = 0;
        end
        held++;
        if (held == 3) m_req[o] = 1'b0;
      end else begin
        in_ten = 1'b0;
        gap++;
        m_req = 4'b1111;
      end
      if (seen.size() < 5) step();
    end
    check_val("rr_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      check_val("rr_order", seen[i], exp_rr[i]);
    end

    // Mux steering for master 2 during a read.
    m_req = 4'b0000;
    step();
    step();
    step();
    m_req = 4'b0100;
    step();
    check_val("m2_gnt", m_gnt, 4'b0100);
    m_address = {$urandom, $urandom};
    m_dataout = {$urandom, $urandom};
    m_address[2*AW +: AW] = 16'h1234;
    m_rd = 4'b1011;
    m_rd[2] = 1'b1;
    bus_ready = 1'b1;
    bus_datain = 16'hBEEF;
    #1;
    check_val("m2_addr", bus_address, 16'h1234);
    check_val("m2_ready", m_ready, 4'b0100);
    check_val("m2_datain", m_datain, 16'hBEEF);
    check_val("m2_rd", bus_rd, 1'b1);
    step();
    m_rd = 4'b0000;
    m_req = 4'b0000;
    step();
    step();

    // Watchdog: master 1 idle while granted is revoked after TO cycles.
    m_req = 4'b0010;
    step();
    cnt = (m_gnt == 4'b0010) ? 1 : 0;
    m_req = 4'b1010;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_gnt == 4'b0010) cnt++;
      else break;
    end
    check_val("wd_cycles", cnt, TO);
    check_val("wd_gap", m_gnt, 4'b0000);
    step();
    check_val("wd_next", m_gnt, 4'b1000);

    // Watchdog hold-off: a write strobe every tenth cycle keeps the grant.
    for (int i = 0; i < 60; i++) begin
      m_wr = (i % 10 == 0) ? 4'b1000 : 4'b0000;
      m_dataout = {$urandom, $urandom};
      step();
      check_val("holdoff_gnt", m_gnt, 4'b1000);
    end

    // Asynchronous reset in the middle of a write.
    m_wr = 4'b1000;
    #1;
    check_val("pre_rst_wr", bus_wr, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_wr", bus_wr, 1'b0);
    check_val("async_gnt", m_gnt, 4'b0000);
    check_val("async_ready", m_ready, 4'b0000);
    model_reset();
    @(negedge clk);
    m_wr = 4'b0000;
    m_req = 4'b0000;
    rst = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      quiet = ((i / 250) % 2) == 1;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) m_req[k] = ~m_req[k];
        m_rd[k] = !quiet && ($urandom_range(5) == 0);
        m_wr[k] = !quiet && ($urandom_range(5) == 0);
      end
      m_address  = {$urandom, $urandom};
      m_dataout  = {$urandom, $urandom};
      bus_datain = 16'($urandom);
      bus_ready  = 1'($urandom);
      rst = ($urandom_range(399) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
